// File: rtl/seq_arith_unit_pkg.sv
// Shared op encodings and sequencer states for the sequential arithmetic unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // mul and div share the op[1] bit; they are the multi-cycle ops
    function automatic logic is_iterative(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/seq_arith_unit_if.sv
// Operand/result bundle between the operand bus and the arithmetic unit.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while busy is low; no queuing.
interface seq_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/seq_arith_unit_addsub.sv
// Combinational (WIDTH+1)-bit adder/subtractor shared by every op.
// Latency: 0 cycles.
// Backpressure: none (pure combinational).
module arith_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    // subtract as x + ~y + 1 so one carry chain serves both directions
    always_comb begin
        sum = x + (sub ? ~y : y) + {{WIDTH{1'b0}}, sub};
    end

endmodule

// File: rtl/seq_arith_unit.sv
// Sequential add/sub/Booth-mul/restoring-div unit with start/busy/done handshake.
// Latency: 2 cycles for add/sub, WIDTH+1 cycles for mul/div.
// Backpressure: start ignored while busy; accepted in IDLE or in the done cycle.
module seq_arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_arith_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t               state;
    state_t               state_nxt;

    logic [1:0]           op_q;
    logic [WIDTH:0]       a_q;       // Booth accumulator / division remainder, with guard bit
    logic [WIDTH-1:0]     q_q;       // multiplier / dividend-then-quotient
    logic                 qm1_q;     // Booth Q-1 bit
    logic [WIDTH-1:0]     m_q;       // multiplicand / divisor / addend
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   res_q;
    logic                 dbz_q;

    logic                 accept;
    logic                 last_iter;
    logic [WIDTH:0]       a_shl;
    logic [WIDTH:0]       alu_x;
    logic [WIDTH:0]       alu_y;
    logic                 alu_sub;
    logic [WIDTH:0]       alu_sum;
    logic [WIDTH:0]       booth_sel;
    logic [WIDTH:0]       a_nxt;
    logic [WIDTH-1:0]     q_nxt;
    logic                 qm1_nxt;

    assign accept    = bus.start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    // {A,Q} shifted left by one, as seen by the divider before its trial subtract
    assign a_shl     = {a_q[WIDTH-1:0], q_q[WIDTH-1]};

    assign bus.busy        = (state == EXEC) || (state == ITER);
    assign bus.done        = (state == DONE);
    assign bus.result      = res_q;
    assign bus.div_by_zero = dbz_q;

    arith_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (alu_x),
        .y   (alu_y),
        .sub (alu_sub),
        .sum (alu_sum)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sequencer next-state: a new start may be taken from IDLE or straight out of DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = is_iterative(bus.op) ? ITER : EXEC;
                end
            end
            EXEC: state_nxt = DONE;
            ITER: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_nxt = is_iterative(bus.op) ? ITER : EXEC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand muxing onto the shared adder for add/sub, Booth step and trial subtract
    always_comb begin
        alu_x   = {q_q[WIDTH-1], q_q};
        alu_y   = {m_q[WIDTH-1], m_q};
        alu_sub = (op_q == OP_SUB);
        if (state == ITER) begin
            if (op_q == OP_MUL) begin
                alu_x   = a_q;
                alu_sub = ({q_q[0], qm1_q} == 2'b10);
            end else begin
                alu_x   = a_shl;
                alu_y   = {1'b0, m_q};
                alu_sub = 1'b1;
            end
        end
    end

    // One iteration of Booth (add/sub then arithmetic shift) or restoring division
    always_comb begin
        booth_sel = a_q;
        a_nxt     = a_q;
        q_nxt     = q_q;
        qm1_nxt   = qm1_q;
        if (op_q == OP_MUL) begin
            if (q_q[0] != qm1_q) begin
                booth_sel = alu_sum;
            end
            a_nxt   = {booth_sel[WIDTH], booth_sel[WIDTH:1]};
            q_nxt   = {booth_sel[0], q_q[WIDTH-1:1]};
            qm1_nxt = q_q[0];
        end else if (alu_sum[WIDTH]) begin
            // trial difference went negative: keep the shifted remainder, quotient bit 0
            a_nxt = a_shl;
            q_nxt = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            a_nxt = alu_sum;
            q_nxt = {q_q[WIDTH-2:0], 1'b1};
        end
    end

    // Datapath registers: latch on accept, step in ITER, publish result on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q  <= 2'b00;
            a_q   <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            op_q  <= bus.op;
            a_q   <= '0;
            q_q   <= bus.a_in;
            qm1_q <= 1'b0;
            m_q   <= bus.b_in;
            cnt_q <= '0;
            dbz_q <= 1'b0;
        end else if (state == EXEC) begin
            res_q <= {{(WIDTH-1){alu_sum[WIDTH]}}, alu_sum};
        end else if (state == ITER) begin
            a_q   <= a_nxt;
            q_q   <= q_nxt;
            qm1_q <= qm1_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
                // with a zero divisor the remainder path ends holding the dividend
                if ((op_q == OP_DIV) && (m_q == '0)) begin
                    res_q <= {a_nxt[WIDTH-1:0], {WIDTH{1'b1}}};
                    dbz_q <= 1'b1;
                end else begin
                    res_q <= {a_nxt[WIDTH-1:0], q_nxt};
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Bench for seq_arith_unit at WIDTH=8: directed vectors with literal answers,
// handshake and reset scenarios, then randomized traffic against a behavioural model.
module tb_seq_arith_unit;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    // model state: cycles of busy still to go, done flag, published result
    int              m_left = 0;
    logic            m_done = 1'b0;
    logic [2*W-1:0]  m_res  = '0;
    logic            m_dbz  = 1'b0;
    logic [2*W-1:0]  p_res  = '0;
    logic            p_dbz  = 1'b0;

    seq_arith_unit_if #(.WIDTH(W)) bus ();

    seq_arith_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic meaning of each op, returned as {div_by_zero, result}
    function automatic logic [2*W:0] ref_calc(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        int sa, sb, ua, ub, r;
        logic [2*W-1:0] res;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r  = 0;
        case (o)
            2'b00: r = sa + sb;
            2'b01: r = sa - sb;
            2'b10: r = sa * sb;
            default: begin
                if (ub == 0) return {1'b1, a, {W{1'b1}}};
                r = ((ua % ub) << W) | (ua / ub);
            end
        endcase
        res = r[2*W-1:0];
        return {1'b0, res};
    endfunction

    // Model timing: an accepted op keeps the unit busy 1 cycle (add/sub) or W cycles (mul/div)
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            m_dbz  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = p_res;
                    m_dbz  = p_dbz;
                    n_done++;
                end
            end else if (bus.start) begin
                {p_dbz, p_res} = ref_calc(bus.op, bus.a_in, bus.b_in);
                m_left = bus.op[1] ? W : 1;
                m_dbz  = 1'b0;
            end
        end
    end

    // Every-cycle compare of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("busy", 32'(bus.busy), 32'(m_left != 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("div_by_zero", 32'(bus.div_by_zero), 32'(m_dbz));
            if (m_left == 0) begin
                check("result", 32'(bus.result), 32'(m_res));
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_res, input logic exp_dbz, input int exp_lat,
                          input string name);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, 32'(bus.result), 32'(exp_res));
        check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
    endtask

    initial begin
        int lat;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst = 1'b1;
        chk_en = 1'b1;

        run_op(2'b00, 8'h64, 8'h64, 16'h00C8, 1'b0, 2, "add_64_64");
        run_op(2'b00, 8'h80, 8'h80, 16'hFF00, 1'b0, 2, "add_80_80");
        run_op(2'b01, 8'h05, 8'h09, 16'hFFFC, 1'b0, 2, "sub_05_09");
        run_op(2'b10, 8'hF9, 8'h0D, 16'hFFA5, 1'b0, 9, "mul_F9_0D");
        run_op(2'b10, 8'h80, 8'h80, 16'h4000, 1'b0, 9, "mul_80_80");
        run_op(2'b10, 8'h7F, 8'h80, 16'hC080, 1'b0, 9, "mul_7F_80");
        run_op(2'b11, 8'hC8, 8'h07, 16'h041C, 1'b0, 9, "div_C8_07");
        run_op(2'b11, 8'hFF, 8'h01, 16'h00FF, 1'b0, 9, "div_FF_01");
        run_op(2'b11, 8'h37, 8'h00, 16'h37FF, 1'b1, 9, "div_37_00");

        // start pulsed in the middle of a multiply must not disturb it
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a_in = 8'hF9; bus.b_in = 8'h0D;
        @(negedge clk);
        bus.start = 1'b0; lat = 1;
        repeat (3) begin @(negedge clk); lat++; end
        bus.start = 1'b1; bus.op = 2'b00; bus.a_in = 8'h01; bus.b_in = 8'h01;
        @(negedge clk);
        bus.start = 1'b0; lat++;
        while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
        check("midmul_latency", 32'(lat), 32'd9);
        check("midmul_result", 32'(bus.result), 32'h0000FFA5);

        // start held high through the done cycle: next op taken with no idle gap
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a_in = 8'h37; bus.b_in = 8'h00;
        @(negedge clk);
        lat = 1;
        while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
        check("held_div_latency", 32'(lat), 32'd9);
        check("held_div_result", 32'(bus.result), 32'h000037FF);
        check("held_div_dbz", 32'(bus.div_by_zero), 32'd1);
        bus.op = 2'b00; bus.a_in = 8'h03; bus.b_in = 8'h04;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_busy", 32'(bus.busy), 32'd1);
        check("b2b_dbz_cleared", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        check("b2b_done", 32'(bus.done), 32'd1);
        check("b2b_result", 32'(bus.result), 32'h00000007);

        // reset in the middle of a multiply clears everything at once
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.a_in = 8'h12; bus.b_in = 8'h34;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_result", 32'(bus.result), 32'd0);
        check("midreset_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        run_op(2'b00, 8'h12, 8'h34, 16'h0046, 1'b0, 2, "post_reset_add");

        // randomized traffic, including starts while busy and back-to-back requests
        n_done = 0;
        repeat (1500) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 3) != 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a_in  = 8'($urandom);
            bus.b_in  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("random_ops_completed", 32'(n_done >= 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised sequential arithmetic unit. Performs signed add, signed subtract, signed radix-2 Booth multiply and unsigned restoring divide on WIDTH-bit operands. It uses an internal sequencer with a start/busy/done handshake, replacing external per-step control strobes. It sits in the ALU datapath between the operand bus and the result mux, and returns a full 2·WIDTH-bit result in one transfer.

## Interface
- WIDTH, 8: operand width; legal range 4..32.
- CNT_W, $clog2(WIDTH): iteration counter width (derived; not overridden).

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- op  input  2  00 add, 01 sub, 10 mul, 11 div; sampled with start
- a_in  input  WIDTH  operand A (dividend for div); sampled with start
- b_in  input  WIDTH  operand B (divisor for div); sampled with start
- busy  output  1  operation in progress; reset 0
- done  output  1  one-cycle pulse when result is valid; reset 0
- result  output  2·WIDTH  see Operation; reset 0
- div_by_zero  output  1  set with done when op=div and B=0; reset 0

## Operation
- States:
  - IDLE: busy=0.
  - EXEC: add/sub, busy=1.
  - ITER: mul/div, busy=1.
  - DONE: busy=0, done=1.
- Transitions:
  - IDLE or DONE with start=1: latch op/A/B, clear counter. Next state is EXEC for add/sub, ITER for mul/div.
  - DONE with start=0: go to IDLE.
  - EXEC: go to DONE.
  - ITER: stay until counter = WIDTH-1, then go to DONE.
- start while busy=1 is ignored; no queuing.
- Add/sub: exact (WIDTH+1)-bit two's-complement sum/difference, sign-extended to 2·WIDTH. No overflow is possible.
- Mul (Booth): registers A (WIDTH+1 bits, sign guard), Q (WIDTH), Q-1.
  - Each iteration: {Q0,Q-1}=01 → A+=M; 10 → A-=M.
  - Then arithmetic shift right of {A,Q,Q-1}.
  - result = {A[WIDTH-1:0], Q}, the signed 2·WIDTH product.
- Div (restoring, unsigned): A (WIDTH+1 bits) cleared, Q = dividend, M = divisor.
  - Each iteration: shift {A,Q} left; A-=M.
  - If A negative: restore A and set Q0=0; else Q0=1.
  - result = {remainder A[WIDTH-1:0], quotient Q}.
- Divide by zero: iterations still run. Required result is {dividend, all-ones}, with div_by_zero=1.
- result and div_by_zero hold from DONE until the next accepted start.
  - On that start, div_by_zero clears.
  - result is undefined-but-stable while busy.
- Reset (any state, including mid-iteration): state IDLE, all registers and outputs 0 immediately.

## Timing
- Start accepted at edge t0.
- Add/sub: result computed at t1; done high for the cycle following t1. Latency is 2 cycles.
- Mul/div: iterations on edges t1..tWIDTH; done high for the cycle following tWIDTH. Latency is WIDTH+1 cycles; for WIDTH=8 that is 9.
- Back-to-back: start high during the done cycle is accepted. Throughput is one op per latency, with zero idle cycles.
- done is never high with busy=1. busy rises the cycle after acceptance.

## Structure
- Package arith_pkg holds:
  - op encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV);
  - state enum (IDLE, EXEC, ITER, DONE).
- Sub-module arith_addsub: combinational (WIDTH+1)-bit add/subtract with op select. It is shared by all ops through operand muxing.
- The top holds the FSM, counter, and A/Q/Q-1/M registers.

## Test plan
All scenarios use WIDTH=8.
- Add/sub:
  - add 0x64+0x64 → result 0x00C8, done 2 cycles after start.
  - add 0x80+0x80 → 0xFF00.
  - sub 0x05−0x09 → 0xFFFC.
- Mul:
  - 0xF9×0x0D (−7×13) → 0xFFA5.
  - 0x80×0x80 → 0x4000.
  - 0x7F×0x80 → 0xC080.
  - done exactly 9 cycles after start.
- Div:
  - 0xC8÷0x07 → 0x041C (r=4, q=28).
  - 0xFF÷0x01 → 0x00FF.
  - 0x37÷0x00 → 0x37FF with div_by_zero=1.
- Handshake:
  - start pulsed mid-mul: ignored, first result unchanged.
  - start held through the done cycle: second op accepted with no idle cycle; div_by_zero cleared.
- Reset: drive rst low at iteration 4 of a mul → busy/done/result/div_by_zero all 0 immediately. After release, a new add completes correctly.
